if_prefetch_stage: RTL and testbench
====================================

# if_prefetch_stage

Parametrised instruction-fetch stage with a prefetch queue. Issues sequential fetches to an instruction memory over a req/ready handshake, buffers {pc, instruction} pairs in a FIFO_DEPTH-entry queue, and delivers them to ID under freeze back-pressure. Branch redirect flushes the queue and discards any in-flight response. Drop-in successor to the single-register fetch stage; output `pc` keeps the "address + step" semantic.

## Interface
- WORD_LENGTH, 32, width of addresses and instructions
- FIFO_DEPTH, 4, prefetch queue entries (power of two, ≥2)
- PC_STEP, 4, address increment per instruction
- RESET_PC, 0, first fetch address after reset

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  ID stall; head entry not consumed
- branch_taken  in  1  redirect request, sampled on clk edge
- branchAddr  in  WORD_LENGTH  redirect target
- imem_req  out  1  fetch request
- imem_addr  out  WORD_LENGTH  fetch address, stable while imem_req=1 until handshake
- imem_ready  in  1  memory returns data; transfer on edge where imem_req&&imem_ready
- imem_rdata  in  WORD_LENGTH  fetched word, valid with imem_ready
- valid  out  1  head entry available to ID
- pc  out  WORD_LENGTH  head fetch address + PC_STEP
- instruction  out  WORD_LENGTH  head instruction
- count  out  $clog2(FIFO_DEPTH+1)  queue occupancy

## Operation
- Reset (rst=0): queue empty, count=0, valid=0, pc=0, instruction=0, fetch_pc=RESET_PC, state=FETCH, imem_req=0 while rst asserted.
- States: FETCH, DROP.
- FETCH: imem_req=1 iff count<FIFO_DEPTH; imem_addr=fetch_pc. On handshake (no branch): push {fetch_pc, imem_rdata}, fetch_pc+=PC_STEP (mod 2^WORD_LENGTH, wraps silently).
- Pop: on edge where valid && !freeze && !branch_taken; head advances.
- Push and pop same edge: count unchanged; legal when full (pop frees slot only next cycle — req stays 0 when count=FIFO_DEPTH).
- Branch in FETCH, imem_req=0 or handshake same edge: queue flushed, response discarded, fetch_pc=branchAddr, stay FETCH.
- Branch in FETCH, imem_req=1 without ready: address cannot change; redirect_pc=branchAddr, queue flushed, go DROP.
- DROP: imem_req=1, imem_addr unchanged; on ready, data discarded, fetch_pc=redirect_pc, go FETCH. Further branch in DROP overwrites redirect_pc (newest wins); branch coinciding with DROP handshake goes FETCH with that branchAddr.
- Branch beats freeze and pop; valid=0 the cycle after any branch.
- Single outstanding request at all times.
- Outputs pc/instruction hold head entry; when valid=0 they are don't-care but must not be X (drive 0 after reset/flush).

## Timing
- Fetch-to-valid: handshake at edge N → valid from cycle after N (1 cycle), head-of-empty-queue.
- Zero-wait memory, no freeze: one instruction per cycle sustained.
- Branch at edge N, memory idle/zero-wait: imem_addr=branchAddr in cycle after N; first target instruction valid two cycles after N.
- Reset release: imem_req=1 with RESET_PC in first cycle after rst deasserts.
- Reset mid-DROP or mid-request: immediate return to reset state; stale response ignored (req=0).

## Configuration
- IF_PREFETCH_BYPASS_EN defined: when queue empty and handshake occurs, valid/pc/instruction driven combinationally from fetch_pc/imem_rdata same cycle; if also popped (!freeze, !branch_taken) entry not written. Fetch-to-valid latency 0, branch-to-valid 1 cycle.
- Not defined: all data passes through the queue; latencies as in Timing.

## Test plan
- Reset, zero-wait memory returning addr as data, freeze=0 → pc sequence 4,8,12,… one per cycle, instruction 0,4,8,….
- freeze=1 for 10 cycles from reset → count saturates at FIFO_DEPTH, imem_req=0; release → four entries drain in order, fetch resumes.
- Memory ready delayed 3 cycles, branch_taken with branchAddr=0x100 in second wait cycle → imem_addr held, response dropped, next request 0x100, first delivered pc=0x104.
- Branch with queue full and freeze=1 → next cycle valid=0, count=0, imem_addr=target.
- Two branches (0x200 then 0x300) during one DROP → only 0x300 fetched.
- fetch_pc=0xFFFFFFFC → next fetch 0x0, delivered pc=0x0.

Source files
------------

// File: rtl/if_prefetch_stage_if.sv
// Instruction-memory fetch bus: one request at a time, transfer on req && ready.
// The fetch stage drives the request side (master); the memory answers (slave).
interface if_prefetch_stage_if #(
  parameter int WORD_LENGTH = 32
);
  logic                   imem_req;
  logic [WORD_LENGTH-1:0] imem_addr;
  logic                   imem_ready;
  logic [WORD_LENGTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a FIFO_DEPTH-entry prefetch queue.
// Issues sequential fetches, queues {fetch address, instruction} pairs and hands
// the head to ID; outputs pc as head address + PC_STEP.  A branch flushes the
// queue; a request already on the bus when the branch arrives is completed and
// its data discarded (DROP state), so only one request is ever outstanding.
// Optional feature macro: IF_PREFETCH_BYPASS_EN -- an empty queue forwards the
// returning word to ID in the same cycle it arrives.
module if_prefetch_stage #(
  parameter int                     WORD_LENGTH = 32,
  parameter int                     FIFO_DEPTH  = 4,
  parameter int                     PC_STEP     = 4,
  parameter logic [WORD_LENGTH-1:0] RESET_PC    = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             freeze,
  input  logic                             branch_taken,
  input  logic [WORD_LENGTH-1:0]           branchAddr,
  if_prefetch_stage_if.master              imem,
  output logic                             valid,
  output logic [WORD_LENGTH-1:0]           pc,
  output logic [WORD_LENGTH-1:0]           instruction,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [WORD_LENGTH-1:0] STEP_W = WORD_LENGTH'(PC_STEP);
  localparam logic [CW-1:0]          FULL_C = CW'(FIFO_DEPTH);

  typedef enum logic {FETCH = 1'b0, DROP = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [WORD_LENGTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_LENGTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [PW-1:0]          head_q, head_d;
  logic [PW-1:0]          tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;

  logic [WORD_LENGTH-1:0] pc_mem_q  [FIFO_DEPTH];
  logic [WORD_LENGTH-1:0] ins_mem_q [FIFO_DEPTH];

  logic hs;
  logic q_valid;
  logic byp;
  logic pop;
  logic q_pop;
  logic push;

  // Request depends only on registered state; reset forces it low so a response
  // arriving while reset is held can never be accepted.
  assign imem.imem_req  = rst && ((state_q == DROP) || (count_q < FULL_C));
  assign imem.imem_addr = fetch_pc_q;

  assign hs      = imem.imem_req && imem.imem_ready;
  assign q_valid = (count_q != '0);

`ifdef IF_PREFETCH_BYPASS_EN
  assign byp = (state_q == FETCH) && !q_valid && hs && !branch_taken;
`else
  assign byp = 1'b0;
`endif

  assign valid = q_valid || byp;
  assign pop   = valid && !freeze && !branch_taken;
  assign q_pop = pop && q_valid;
  // A bypassed word that ID consumes immediately never enters the queue.
  assign push  = (state_q == FETCH) && hs && !branch_taken && !(byp && pop);
  assign count = count_q;

  // Head entry to ID; zero when nothing is valid so ID never sees X.
  always_comb begin
    pc          = '0;
    instruction = '0;
    if (q_valid) begin
      pc          = pc_mem_q[head_q] + STEP_W;
      instruction = ins_mem_q[head_q];
    end else if (byp) begin
      pc          = fetch_pc_q + STEP_W;
      instruction = imem.imem_rdata;
    end
  end

  // Next-state: branch has priority over everything, then DROP completion,
  // then normal push/pop traffic.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (branch_taken) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      if (state_q == FETCH) begin
        if (!imem.imem_req || hs) begin
          fetch_pc_d = branchAddr;
        end else begin
          // Address is locked on the bus until the handshake; remember the target.
          redirect_pc_d = branchAddr;
          state_d       = DROP;
        end
      end else begin
        if (hs) begin
          fetch_pc_d = branchAddr;
          state_d    = FETCH;
        end else begin
          redirect_pc_d = branchAddr;
        end
      end
    end else if (state_q == DROP) begin
      if (hs) begin
        fetch_pc_d = redirect_pc_q;
        state_d    = FETCH;
      end
    end else begin
      if (hs) begin
        fetch_pc_d = fetch_pc_q + STEP_W;
      end
      if (push) begin
        tail_d = tail_q + PW'(1);
      end
      if (q_pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(q_pop);
    end
  end

  // Control state and queue pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // Queue storage; contents are only observed through a valid head, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]  <= fetch_pc_q;
      ins_mem_q[tail_q] <= imem.imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed scenarios followed by random traffic,
// every cycle compared with a queue-based reference model.
module tb_if_prefetch_stage;

  localparam int          W    = 32;
  localparam int          D    = 4;
  localparam int          STEP = 4;
  localparam logic [31:0] RPC  = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branchAddr = '0;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [2:0]  count;
  logic        ready = 1'b0;
  logic [31:0] xorv = '0;

  if_prefetch_stage_if #(.WORD_LENGTH(W)) mif ();

  // Memory: combinational, data is the address scrambled by xorv.
  assign mif.imem_ready = ready;
  assign mif.imem_rdata = mif.imem_addr ^ xorv;

  if_prefetch_stage #(
    .WORD_LENGTH(W), .FIFO_DEPTH(D), .PC_STEP(STEP), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branchAddr(branchAddr), .imem(mif), .valid(valid), .pc(pc),
    .instruction(instruction), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq_pc[$];
  logic [31:0] mq_in[$];
  logic [31:0] m_fpc;
  logic [31:0] m_redir;
  bit          m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq_pc.delete();
    mq_in.delete();
    m_fpc   = RPC;
    m_redir = '0;
    m_drop  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    branch_taken = 1'b0;
    freeze = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_req",   32'(mif.imem_req), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pc",    pc, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One clock: compare at the falling edge, advance the model to the rising edge.
  task automatic cycle();
    bit          e_req, e_valid, hs, byp;
    logic [31:0] e_pc, e_in;
    @(negedge clk);
    e_req = m_drop || (mq_pc.size() < D);
    hs    = e_req && ready;
    byp   = 1'b0;
`ifdef IF_PREFETCH_BYPASS_EN
    byp = !m_drop && (mq_pc.size() == 0) && hs && !branch_taken;
`endif
    e_valid = (mq_pc.size() > 0) || byp;
    e_pc = '0;
    e_in = '0;
    if (mq_pc.size() > 0) begin
      e_pc = mq_pc[0] + STEP;
      e_in = mq_in[0];
    end else if (byp) begin
      e_pc = m_fpc + STEP;
      e_in = m_fpc ^ xorv;
    end
    chk("count", 32'(count), 32'(mq_pc.size()));
    chk("req", 32'(mif.imem_req), 32'(e_req));
    if (e_req) chk("addr", mif.imem_addr, m_fpc);
    chk("valid", 32'(valid), 32'(e_valid));
    if (e_valid) begin
      chk("pc", pc, e_pc);
      chk("instr", instruction, e_in);
    end else begin
      chk("out_known", 32'($isunknown({pc, instruction})), 32'd0);
    end
    // Model update for the coming edge
    if (branch_taken) begin
      mq_pc.delete();
      mq_in.delete();
      if (m_drop) begin
        if (hs) begin m_drop = 1'b0; m_fpc = branchAddr; end
        else m_redir = branchAddr;
      end else begin
        if (!e_req || hs) m_fpc = branchAddr;
        else begin m_drop = 1'b1; m_redir = branchAddr; end
      end
    end else if (m_drop) begin
      if (hs) begin m_drop = 1'b0; m_fpc = m_redir; end
    end else begin
      if (byp && !freeze) begin
        // word consumed straight from the bus, queue untouched
      end else begin
        if (e_valid && !freeze) begin
          void'(mq_pc.pop_front());
          void'(mq_in.pop_front());
        end
        if (hs) begin
          mq_pc.push_back(m_fpc);
          mq_in.push_back(m_fpc ^ xorv);
        end
      end
      if (hs) m_fpc = m_fpc + STEP;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // Zero-wait sequential fetch, data = address
    ready = 1'b1;
    repeat (12) cycle();

    // Freeze from reset: queue fills, request stops, then drains in order
    do_reset();
    ready = 1'b1; freeze = 1'b1;
    repeat (10) cycle();
    freeze = 1'b0;
    repeat (10) cycle();

    // Slow memory, branch to 0x100 in the second wait cycle
    do_reset();
    ready = 1'b0;
    cycle();
    branch_taken = 1'b1; branchAddr = 32'h100;
    cycle();
    branch_taken = 1'b0;
    cycle();
    ready = 1'b1;
    repeat (6) cycle();

    // Branch with queue full and freeze held
    freeze = 1'b1;
    repeat (6) cycle();
    branch_taken = 1'b1; branchAddr = 32'h40;
    cycle();
    branch_taken = 1'b0; freeze = 1'b0;
    repeat (6) cycle();

    // Two branches during one DROP: newest target wins
    do_reset();
    ready = 1'b0;
    cycle();
    branch_taken = 1'b1; branchAddr = 32'h200;
    cycle();
    branchAddr = 32'h300;
    cycle();
    branch_taken = 1'b0;
    cycle();
    ready = 1'b1;
    repeat (6) cycle();

    // Address wrap at the top of the space
    branch_taken = 1'b1; branchAddr = 32'hFFFF_FFFC;
    cycle();
    branch_taken = 1'b0;
    repeat (6) cycle();

    // Reset while in DROP
    ready = 1'b0;
    cycle();
    branch_taken = 1'b1; branchAddr = 32'h500;
    cycle();
    branch_taken = 1'b0;
    do_reset();
    ready = 1'b1;
    repeat (4) cycle();

    // Random traffic
    xorv = $urandom;
    for (int i = 0; i < 600; i++) begin
      ready        = ($urandom_range(0, 3) != 0);
      freeze       = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 15) == 0);
      branchAddr   = $urandom & 32'hFFFF_FFFC;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
